mem_stage_unit: RTL and testbench

Parametrised MEM stage for the 5-stage pipeline. It sits between EX and WB and owns the word-addressed data memory. It executes loads and stores with a configurable access latency and stalls EX through a valid/ready handshake. It presents a registered MEM/WB result (data, destination register, line number, write enable, error) as a one-cycle `wb_valid` pulse per retired instruction.

---
 rtl/mem_stage_unit_if.sv | 34 +++
 rtl/mem_stage_unit.sv | 149 ++++++++++++++
 tb/tb_mem_stage_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_unit_if.sv
// EX->MEM request and MEM->WB retire bundle for mem_stage_unit.
// Ports: in_valid/in_ready handshake with instruction, aluoutput, writedata, registernum, linenum;
//        wb_valid retire pulse with wb_data, wb_regnum, wb_linenum, wb_we, wb_err.
interface mem_stage_unit_if #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 4,
   parameter int LINE_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        instruction;
   logic [DATA_W-1:0] aluoutput;
   logic [DATA_W-1:0] writedata;
   logic [REG_W-1:0]  registernum;
   logic [LINE_W-1:0] linenum;
   logic              wb_valid;
   logic [DATA_W-1:0] wb_data;
   logic [REG_W-1:0]  wb_regnum;
   logic [LINE_W-1:0] wb_linenum;
   logic              wb_we;
   logic              wb_err;

   // EX side: presents instructions, observes the retire bus.
   modport master (
      output in_valid, instruction, aluoutput, writedata, registernum, linenum,
      input  in_ready, wb_valid, wb_data, wb_regnum, wb_linenum, wb_we, wb_err
   );

   // MEM stage side.
   modport slave (
      input  in_valid, instruction, aluoutput, writedata, registernum, linenum,
      output in_ready, wb_valid, wb_data, wb_regnum, wb_linenum, wb_we, wb_err
   );
endinterface

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage owning a word-addressed data memory; loads/stores take LAT extra cycles.
// Latency: in-range LW/SW registered at accept edge + LAT, everything else at the accept edge.
// Backpressure: in_ready low for LAT cycles after an in-range LW/SW accept; ports: clkwire, resetn, bus (slave).
module mem_stage_unit #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int REG_W  = 4,
   parameter int LINE_W = 4,
   parameter int LAT    = 0
) (
   input  logic              clkwire,
   input  logic              resetn,
   mem_stage_unit_if.slave   bus
);
   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_LW  = 4'b0011;
   localparam logic [3:0] OP_SW  = 4'b0100;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state;
   logic [2:0]        cnt;
   logic [3:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [REG_W-1:0]  reg_q;
   logic [LINE_W-1:0] line_q;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   logic              accept;
   logic              is_mem;
   logic              oor;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   assign bus.in_ready = resetn && (state == IDLE);
   assign accept       = bus.in_valid && bus.in_ready;
   assign is_mem       = (bus.instruction == OP_LW) || (bus.instruction == OP_SW);
   // Any address bit beyond the memory depth makes the access illegal.
   assign oor          = |(bus.aluoutput >> ADDR_W);

   // One memory port: the latched operation owns it while BUSY, the incoming one otherwise.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = bus.aluoutput[ADDR_W-1:0];
      mem_wdata = bus.writedata;
      if (state == BUSY) begin
         mem_addr  = addr_q;
         mem_wdata = data_q;
         mem_we    = resetn && (cnt == 3'd1) && (op_q == OP_SW);
      end else begin
         mem_we    = resetn && accept && (bus.instruction == OP_SW) && !oor && (LAT == 0);
      end
   end

   assign mem_rdata = mem[mem_addr];

   // Storage is deliberately not reset.
   always_ff @(posedge clkwire) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   always_ff @(posedge clkwire) begin
      if (!resetn) begin
         state          <= IDLE;
         cnt            <= 3'd0;
         op_q           <= 4'd0;
         addr_q         <= '0;
         data_q         <= '0;
         reg_q          <= '0;
         line_q         <= '0;
         bus.wb_valid   <= 1'b0;
         bus.wb_data    <= '0;
         bus.wb_regnum  <= '0;
         bus.wb_linenum <= '0;
         bus.wb_we      <= 1'b0;
         bus.wb_err     <= 1'b0;
      end else begin
         bus.wb_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_mem && !oor && (LAT != 0)) begin
                     op_q   <= bus.instruction;
                     addr_q <= bus.aluoutput[ADDR_W-1:0];
                     data_q <= bus.writedata;
                     reg_q  <= bus.registernum;
                     line_q <= bus.linenum;
                     cnt    <= 3'(LAT);
                     state  <= BUSY;
                  end else begin
                     bus.wb_valid   <= 1'b1;
                     bus.wb_regnum  <= bus.registernum;
                     bus.wb_linenum <= bus.linenum;
                     bus.wb_err     <= 1'b0;
                     if (is_mem && oor) begin
                        bus.wb_data <= '0;
                        bus.wb_we   <= 1'b0;
                        bus.wb_err  <= 1'b1;
                     end else begin
                        case (bus.instruction)
                           OP_NOP: begin
                              bus.wb_data <= '0;
                              bus.wb_we   <= 1'b0;
                           end
                           OP_LW: begin
                              bus.wb_data <= mem_rdata;
                              bus.wb_we   <= 1'b1;
                           end
                           OP_SW: begin
                              bus.wb_data <= '0;
                              bus.wb_we   <= 1'b0;
                           end
                           default: begin
                              bus.wb_data <= bus.aluoutput;
                              bus.wb_we   <= 1'b1;
                           end
                        endcase
                     end
                  end
               end
            end
            BUSY: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) begin
                  state          <= IDLE;
                  bus.wb_valid   <= 1'b1;
                  bus.wb_regnum  <= reg_q;
                  bus.wb_linenum <= line_q;
                  bus.wb_err     <= 1'b0;
                  if (op_q == OP_LW) begin
                     bus.wb_data <= mem_rdata;
                     bus.wb_we   <= 1'b1;
                  end else begin
                     bus.wb_data <= '0;
                     bus.wb_we   <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: three instances with LAT = 0, 2, 3 share clock and reset.
// Stimulus pushes expected retirements (with due cycle) into a queue; a negedge monitor pops and compares.
// Ports exercised: full request handshake and retire bus of every instance.
module tb_mem_stage_unit;
   localparam logic [3:0] NOP = 4'b0000;
   localparam logic [3:0] LW  = 4'b0011;
   localparam logic [3:0] SW  = 4'b0100;

   typedef struct {
      int          dut;
      logic [15:0] data;
      logic [3:0]  rn;
      logic [3:0]  ln;
      logic        we;
      logic        err;
      int          due;
   } exp_t;

   logic clk;
   logic resetn;
   int   cyc;
   int   nvec;
   int   nfail;
   bit   mon_en;
   exp_t exp_q[$];

   logic        drv_valid [3];
   logic [3:0]  drv_op    [3];
   logic [15:0] drv_alu   [3];
   logic [15:0] drv_wd    [3];
   logic [3:0]  drv_rn    [3];
   logic [3:0]  drv_ln    [3];

   logic        m_rdy   [3];
   logic        m_valid [3];
   logic [15:0] m_data  [3];
   logic [3:0]  m_rn    [3];
   logic [3:0]  m_ln    [3];
   logic        m_we    [3];
   logic        m_err   [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_stage_unit_if #(.DATA_W(16), .REG_W(4), .LINE_W(4)) bus ();
      assign bus.in_valid    = drv_valid[g];
      assign bus.instruction = drv_op[g];
      assign bus.aluoutput   = drv_alu[g];
      assign bus.writedata   = drv_wd[g];
      assign bus.registernum = drv_rn[g];
      assign bus.linenum     = drv_ln[g];
      assign m_rdy[g]        = bus.in_ready;
      assign m_valid[g]      = bus.wb_valid;
      assign m_data[g]       = bus.wb_data;
      assign m_rn[g]         = bus.wb_regnum;
      assign m_ln[g]         = bus.wb_linenum;
      assign m_we[g]         = bus.wb_we;
      assign m_err[g]        = bus.wb_err;
      mem_stage_unit #(
         .DATA_W(16), .ADDR_W(8), .REG_W(4), .LINE_W(4),
         .LAT((g == 0) ? 0 : ((g == 1) ? 2 : 3))
      ) dut (
         .clkwire(clk),
         .resetn (resetn),
         .bus    (bus)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit, vectors=%0d", nvec);
      $fatal(1, "watchdog");
   end

   // Monitor: every retire pulse must match the oldest outstanding expectation, at its due cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 3; i++) begin
            if (m_valid[i]) begin
               nvec++;
               if (exp_q.size() == 0) begin
                  nfail++;
                  $display("FAIL unexpected_wb dut=%0d cyc=%0d: got data=%h we=%b err=%b, required no retirement",
                           i, cyc, m_data[i], m_we[i], m_err[i]);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  if (e.dut != i || e.due != cyc || m_data[i] !== e.data || m_rn[i] !== e.rn ||
                      m_ln[i] !== e.ln || m_we[i] !== e.we || m_err[i] !== e.err) begin
                     nfail++;
                     $display("FAIL retire: got dut=%0d cyc=%0d data=%h rn=%0d ln=%0d we=%b err=%b, required dut=%0d cyc=%0d data=%h rn=%0d ln=%0d we=%b err=%b",
                              i, cyc, m_data[i], m_rn[i], m_ln[i], m_we[i], m_err[i],
                              e.dut, e.due, e.data, e.rn, e.ln, e.we, e.err);
                  end
               end
            end
         end
      end
   end

   task automatic clear_drv();
      for (int i = 0; i < 3; i++) begin
         drv_valid[i] = 1'b0;
         drv_op[i]    = NOP;
         drv_alu[i]   = 16'h0;
         drv_wd[i]    = 16'h0;
         drv_rn[i]    = 4'h0;
         drv_ln[i]    = 4'h0;
      end
   endtask

   // Present one instruction on instance d, wait for acceptance, and register its expected retirement.
   // exp_wait >= 0 also checks how many cycles in_ready stayed low before the accept.
   task automatic issue(input int d, input logic [3:0] op, input logic [15:0] alu, input logic [15:0] wd,
                        input logic [3:0] rn, input logic [3:0] ln,
                        input logic [15:0] edata, input logic ewe, input logic eerr,
                        input int lat_eff, input int exp_wait);
      exp_t e;
      int   w;
      @(negedge clk);
      for (int i = 0; i < 3; i++) drv_valid[i] = 1'b0;
      drv_valid[d] = 1'b1;
      drv_op[d]    = op;
      drv_alu[d]   = alu;
      drv_wd[d]    = wd;
      drv_rn[d]    = rn;
      drv_ln[d]    = ln;
      w = 0;
      while (!m_rdy[d] && w < 40) begin
         @(negedge clk);
         w++;
      end
      nvec++;
      if (w >= 40) begin
         nfail++;
         $display("FAIL accept_timeout dut=%0d op=%h: in_ready=0 after %0d cycles, required 1", d, op, w);
         drv_valid[d] = 1'b0;
      end else begin
         if (exp_wait >= 0 && w != exp_wait) begin
            nfail++;
            $display("FAIL ready_wait dut=%0d op=%h: waited %0d cycles, required %0d", d, op, w, exp_wait);
         end
         e.dut  = d;
         e.data = edata;
         e.rn   = rn;
         e.ln   = ln;
         e.we   = ewe;
         e.err  = eerr;
         e.due  = cyc + 1 + lat_eff;
         exp_q.push_back(e);
         @(posedge clk);
      end
   endtask

   task automatic go_idle(input int n);
      @(negedge clk);
      for (int i = 0; i < 3; i++) drv_valid[i] = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      cyc    = 0;
      nvec   = 0;
      nfail  = 0;
      mon_en = 1'b0;
      clear_drv();
      resetn = 1'b0;

      // Reset with requests pending: nothing may be accepted and the retire bus must be cleared.
      for (int i = 0; i < 3; i++) begin
         drv_valid[i] = 1'b1;
         drv_op[i]    = 4'h1;
         drv_alu[i]   = 16'h1234;
      end
      @(posedge clk);
      mon_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         nvec++;
         if (m_rdy[i] !== 1'b0 || m_valid[i] !== 1'b0 || m_data[i] !== 16'h0 || m_rn[i] !== 4'h0 ||
             m_ln[i] !== 4'h0 || m_we[i] !== 1'b0 || m_err[i] !== 1'b0) begin
            nfail++;
            $display("FAIL reset_state dut=%0d: got rdy=%b valid=%b data=%h rn=%0d ln=%0d we=%b err=%b, required all 0",
                     i, m_rdy[i], m_valid[i], m_data[i], m_rn[i], m_ln[i], m_we[i], m_err[i]);
         end
      end
      clear_drv();
      resetn = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         nvec++;
         if (m_rdy[i] !== 1'b1) begin
            nfail++;
            $display("FAIL ready_after_reset dut=%0d: got %b, required 1", i, m_rdy[i]);
         end
      end
      repeat (3) @(negedge clk);

      // LAT=0: store/load, out-of-range, ALU, NOP, top address.
      issue(0, SW,   16'h0004, 16'hBEEF, 4'd1, 4'd1, 16'h0000, 1'b0, 1'b0, 0, 0);
      issue(0, LW,   16'h0004, 16'h0000, 4'd6, 4'd9, 16'hBEEF, 1'b1, 1'b0, 0, 0);
      issue(0, SW,   16'h0104, 16'h1111, 4'd2, 4'd3, 16'h0000, 1'b0, 1'b1, 0, 0);
      issue(0, LW,   16'h0004, 16'h0000, 4'd7, 4'd4, 16'hBEEF, 1'b1, 1'b0, 0, 0);
      issue(0, 4'h1, 16'h0004, 16'h0000, 4'd5, 4'd2, 16'h0004, 1'b1, 1'b0, 0, 0);
      issue(0, 4'h2, 16'hFF00, 16'h0000, 4'd8, 4'd5, 16'hFF00, 1'b1, 1'b0, 0, 0);
      issue(0, NOP,  16'h0000, 16'h0000, 4'd3, 4'd6, 16'h0000, 1'b0, 1'b0, 0, 0);
      issue(0, LW,   16'h8004, 16'h0000, 4'd9, 4'd7, 16'h0000, 1'b0, 1'b1, 0, 0);
      issue(0, SW,   16'h00FF, 16'hA5A5, 4'd1, 4'd8, 16'h0000, 1'b0, 1'b0, 0, 0);
      issue(0, LW,   16'h00FF, 16'h0000, 4'd4, 4'd8, 16'hA5A5, 1'b1, 1'b0, 0, 0);
      go_idle(3);

      // LAT=2: in_valid held high across back-to-back requests.
      issue(1, SW,   16'h0004, 16'hBEEF, 4'd1, 4'd1, 16'h0000, 1'b0, 1'b0, 2, 0);
      issue(1, LW,   16'h0004, 16'h0000, 4'd6, 4'd9, 16'hBEEF, 1'b1, 1'b0, 2, 2);
      issue(1, 4'h1, 16'h0004, 16'h0000, 4'd5, 4'd2, 16'h0004, 1'b1, 1'b0, 0, 2);
      issue(1, 4'h5, 16'h0077, 16'h0000, 4'd4, 4'd3, 16'h0077, 1'b1, 1'b0, 0, 0);
      issue(1, SW,   16'h0104, 16'h1111, 4'd2, 4'd3, 16'h0000, 1'b0, 1'b1, 0, 0);
      issue(1, LW,   16'h0004, 16'h0000, 4'd7, 4'd4, 16'hBEEF, 1'b1, 1'b0, 2, 0);
      go_idle(4);

      // LAT=3: establish memory contents, then reset in the middle of a store.
      issue(2, SW,   16'h0004, 16'hBEEF, 4'd1, 4'd1, 16'h0000, 1'b0, 1'b0, 3, 0);
      issue(2, LW,   16'h0004, 16'h0000, 4'd6, 4'd9, 16'hBEEF, 1'b1, 1'b0, 3, 3);
      go_idle(5);

      @(negedge clk);
      drv_valid[2] = 1'b1;
      drv_op[2]    = SW;
      drv_alu[2]   = 16'h0004;
      drv_wd[2]    = 16'h5555;
      drv_rn[2]    = 4'd2;
      drv_ln[2]    = 4'd2;
      nvec++;
      if (m_rdy[2] !== 1'b1) begin
         nfail++;
         $display("FAIL ready_before_abort: got %b, required 1", m_rdy[2]);
      end
      @(posedge clk);
      @(negedge clk);
      drv_valid[2] = 1'b0;
      resetn       = 1'b0;
      nvec++;
      if (m_rdy[2] !== 1'b0) begin
         nfail++;
         $display("FAIL ready_in_reset: got %b, required 0", m_rdy[2]);
      end
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      nvec++;
      if (m_rdy[2] !== 1'b1 || m_valid[2] !== 1'b0) begin
         nfail++;
         $display("FAIL abort_idle: got rdy=%b valid=%b, required rdy=1 valid=0", m_rdy[2], m_valid[2]);
      end
      repeat (5) @(negedge clk);
      issue(2, LW,   16'h0004, 16'h0000, 4'd3, 4'd5, 16'hBEEF, 1'b1, 1'b0, 3, 0);
      go_idle(8);

      nvec++;
      if (exp_q.size() != 0) begin
         nfail++;
         $display("FAIL drain: %0d expected retirements never seen, required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
